// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, 8-beat line fill over the shared bus.
// Optional feature macro: ICACHE_FORWARD_EN (forward the demanded word straight from the bus during a fill).
module instr_cache #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_LINES      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               pc,
    input  logic [63:0]               stackptr,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      data_ack,
    output logic [31:0]               instr_reg,
    output logic                      icache_busreq,
    output logic                      icache_busidle,
    input  logic                      icache_busgrant
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LINE_W = 58;
    localparam int TAG_W  = LINE_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_REQ  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [LINE_W-1:0]       fill_addr_q, fill_addr_d;
    logic [2:0]              beat_cnt_q, beat_cnt_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [NUM_LINES];
    logic [63:0]             mem_q [NUM_LINES*8];

    logic [IDX_W-1:0]        pc_idx_s;
    logic [TAG_W-1:0]        pc_tag_s;
    logic [2:0]              pc_beat_s;
    logic [IDX_W-1:0]        fill_idx_s;
    logic [TAG_W-1:0]        fill_tag_s;
    logic [63:0]             rd_beat_s;
    logic                    hit_s;
    logic                    beat_take_s;
    logic                    fill_done_s;
    logic                    unused_inputs_s;

    assign pc_idx_s    = pc[6 +: IDX_W];
    assign pc_tag_s    = pc[63 -: TAG_W];
    assign pc_beat_s   = pc[5:3];
    assign fill_idx_s  = fill_addr_q[IDX_W-1:0];
    assign fill_tag_s  = fill_addr_q[LINE_W-1 -: TAG_W];
    assign rd_beat_s   = mem_q[{pc_idx_s, pc_beat_s}];
    assign hit_s       = (state_q == S_IDLE) && valid_q[pc_idx_s] && (tag_q[pc_idx_s] == pc_tag_s);
    // Beats arriving while reset is held belong to an abandoned fill.
    assign beat_take_s = (state_q == S_RESP) && bus_respcyc && !reset;
    assign fill_done_s = beat_take_s && (beat_cnt_q == 3'd7);
    assign bus_reqtag  = 13'h1100;

    assign unused_inputs_s = ^{stackptr, bus_resptag, pc[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: miss -> arbitrate -> request -> collect 8 beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hit_s) state_d = S_IDLE;
                else       state_d = S_ARB;
            end
            S_ARB: begin
                if (icache_busgrant) state_d = S_REQ;
                else                 state_d = S_ARB;
            end
            S_REQ: begin
                if (bus_reqack) state_d = S_RESP;
                else            state_d = S_REQ;
            end
            S_RESP: begin
                if (fill_done_s) state_d = S_IDLE;
                else             state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fill bookkeeping: latched line address, beat counter, valid bits.
    always_comb begin
        fill_addr_d = fill_addr_q;
        beat_cnt_d  = beat_cnt_q;
        valid_d     = valid_q;
        if ((state_q == S_IDLE) && !hit_s) begin
            fill_addr_d = pc[63:6];
        end else begin
            fill_addr_d = fill_addr_q;
        end
        if ((state_q == S_REQ) && bus_reqack) begin
            beat_cnt_d = 3'd0;
        end else if (beat_take_s) begin
            beat_cnt_d = beat_cnt_q + 3'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        if (fill_done_s) begin
            valid_d[fill_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_addr_q <= {LINE_W{1'b0}};
            beat_cnt_q  <= 3'd0;
            valid_q     <= {NUM_LINES{1'b0}};
        end else begin
            fill_addr_q <= fill_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            valid_q     <= valid_d;
        end
    end

    // Line data and tag arrays; contents are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (beat_take_s) begin
            mem_q[{fill_idx_s, beat_cnt_q}] <= bus_resp;
        end
        if (fill_done_s) begin
            tag_q[fill_idx_s] <= fill_tag_s;
        end
    end

    // Output decode from the current state.
    always_comb begin
        bus_reqcyc     = 1'b0;
        bus_req        = 64'h0;
        bus_respack    = 1'b0;
        data_ack       = 1'b0;
        instr_reg      = 32'h0;
        icache_busreq  = 1'b0;
        icache_busidle = 1'b1;
        if (reset) begin
            icache_busidle = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    icache_busidle = 1'b1;
                    data_ack       = hit_s;
                    if (hit_s) instr_reg = pc[2] ? rd_beat_s[63:32] : rd_beat_s[31:0];
                    else       instr_reg = 32'h0;
                end
                S_ARB: begin
                    icache_busreq  = 1'b1;
                    icache_busidle = 1'b1;
                end
                S_REQ: begin
                    icache_busreq  = 1'b1;
                    icache_busidle = 1'b0;
                    bus_reqcyc     = 1'b1;
                    bus_req        = {fill_addr_q, 6'b0};
                end
                S_RESP: begin
                    icache_busreq  = 1'b1;
                    icache_busidle = 1'b0;
                    bus_respack    = bus_respcyc;
`ifdef ICACHE_FORWARD_EN
                    if (bus_respcyc && (beat_cnt_q == pc_beat_s) && (pc[63:6] == fill_addr_q)) begin
                        data_ack  = 1'b1;
                        instr_reg = pc[2] ? bus_resp[63:32] : bus_resp[31:0];
                    end else begin
                        data_ack  = 1'b0;
                        instr_reg = 32'h0;
                    end
`endif
                end
                default: begin
                    icache_busidle = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache; covers forwarding when ICACHE_FORWARD_EN is defined.
module tb_instr_cache;

`ifdef ICACHE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic [63:0] stackptr;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        data_ack;
    logic [31:0] instr_reg;
    logic        icache_busreq;
    logic        icache_busidle;
    logic        icache_busgrant;

    int checks = 0;
    int errors = 0;

    instr_cache dut (
        .clk(clk), .reset(reset), .pc(pc), .stackptr(stackptr),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack), .data_ack(data_ack),
        .instr_reg(instr_reg), .icache_busreq(icache_busreq),
        .icache_busidle(icache_busidle), .icache_busgrant(icache_busgrant)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        #1;
        check_eq("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check_eq("rst_respack", 64'(bus_respack), 64'd0);
        check_eq("rst_busreq", 64'(icache_busreq), 64'd0);
        check_eq("rst_busidle", 64'(icache_busidle), 64'd1);
        check_eq("rst_data_ack", 64'(data_ack), 64'd0);
        check_eq("rst_bus_req", bus_req, 64'd0);
    endtask

    // Full miss from IDLE; beat k carries {2k+1+salt, 2k+salt}.
    task automatic run_miss(input logic [63:0] addr, input int grant_wait, input int gap,
                            input logic [31:0] salt, input int nbeats);
        logic [31:0] lo, hi, fexp;
        pc = addr;
        #1;
        check_eq("miss_ack", 64'(data_ack), 64'd0);
        tick();
        check_eq("arb_busreq", 64'(icache_busreq), 64'd1);
        check_eq("arb_busidle", 64'(icache_busidle), 64'd1);
        for (int i = 0; i < grant_wait; i++) begin
            tick();
            check_eq("stall_busreq", 64'(icache_busreq), 64'd1);
            check_eq("stall_reqcyc", 64'(bus_reqcyc), 64'd0);
            check_eq("stall_busidle", 64'(icache_busidle), 64'd1);
        end
        icache_busgrant = 1'b1;
        tick();
        icache_busgrant = 1'b0;
        check_eq("req_reqcyc", 64'(bus_reqcyc), 64'd1);
        check_eq("req_addr", bus_req, {addr[63:6], 6'b0});
        check_eq("req_tag", 64'(bus_reqtag), 64'h1100);
        check_eq("req_busidle", 64'(icache_busidle), 64'd0);
        tick();
        check_eq("req_hold", 64'(bus_reqcyc), 64'd1);
        check_eq("req_hold_addr", bus_req, {addr[63:6], 6'b0});
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        check_eq("resp_reqcyc", 64'(bus_reqcyc), 64'd0);
        for (int k = 0; k < nbeats; k++) begin
            if (gap != 0) begin
                bus_respcyc = 1'b0;
                #1;
                check_eq("gap_respack", 64'(bus_respack), 64'd0);
                tick();
            end
            lo = 32'(2 * k) + salt;
            hi = 32'(2 * k + 1) + salt;
            bus_respcyc = 1'b1;
            bus_resp    = {hi, lo};
            #1;
            check_eq("beat_respack", 64'(bus_respack), 64'd1);
            fexp = (FWD && (k == int'(addr[5:3]))) ? (addr[2] ? hi : lo) : 32'h0;
            check_eq("beat_ack", 64'(data_ack), (FWD && (k == int'(addr[5:3]))) ? 64'd1 : 64'd0);
            check_eq("beat_instr", 64'(instr_reg), 64'(fexp));
            tick();
        end
        if (nbeats == 8) begin
            bus_respcyc = 1'b0;
            #1;
            lo = 32'(2 * int'(addr[5:3])) + salt;
            check_eq("fill_ack", 64'(data_ack), 64'd1);
            check_eq("fill_instr", 64'(instr_reg), 64'(addr[2] ? lo + 32'd1 : lo));
            check_eq("fill_busreq", 64'(icache_busreq), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; pc = 64'h1000; stackptr = 64'h0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'h0;
        bus_resptag = 13'h0; icache_busgrant = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs();

        // Cold miss, then hit sweep with no bus traffic.
        run_miss(64'h1000, 2, 0, 32'h0, 8);
        pc = 64'h1004; #1;
        check_eq("hit_ack_1004", 64'(data_ack), 64'd1);
        check_eq("hit_instr_1004", 64'(instr_reg), 64'h1);
        tick();
        pc = 64'h103C; #1;
        check_eq("hit_ack_103c", 64'(data_ack), 64'd1);
        check_eq("hit_instr_103c", 64'(instr_reg), 64'hF);
        check_eq("hit_busreq", 64'(icache_busreq), 64'd0);
        tick();
        check_eq("hit_reqcyc", 64'(bus_reqcyc), 64'd0);
        check_eq("hit_idle", 64'(icache_busidle), 64'd1);

        // Conflict eviction on index 0.
        run_miss(64'h2000, 0, 0, 32'h100, 8);
        pc = 64'h200C; #1;
        check_eq("evict_instr_200c", 64'(instr_reg), 64'h103);
        run_miss(64'h1000, 1, 0, 32'h0, 8);

        // Stalled grant and gapped beats.
        run_miss(64'h1040, 10, 1, 32'h200, 8);
        pc = 64'h1000; #1;
        check_eq("other_line_hit", 64'(data_ack), 64'd1);

        // Reset in the middle of a fill; remaining beats must be ignored.
        run_miss(64'h1080, 0, 0, 32'h300, 4);
        reset = 1'b1;
        bus_resp = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        reset = 1'b0;
        check_reset_outputs();
        pc = 64'h1080; #1;
        check_eq("no_partial_valid", 64'(data_ack), 64'd0);
        bus_respcyc = 1'b0;
        pc = 64'h1000; #1;
        check_eq("post_rst_miss", 64'(data_ack), 64'd0);
        run_miss(64'h1000, 0, 0, 32'h0, 8);

        // Word 0x1018 in beat 3 (forwarded from the bus when enabled).
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_miss(64'h1018, 0, 0, 32'h0, 8);
        check_eq("fwd_line_instr", 64'(instr_reg), 64'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
